instr_encoder: RTL and testbench

- Inverse of the decode-stage immediate generator. Packs register fields, function fields and a 32-bit sign-extended immediate into a 32-bit RV32I instruction word for formats R/I/S/B/U/J.
- Used by the self-test/boot sequencer and by the verification trace-replay path to build instruction streams for the core.
- One-stage registered pipeline with valid/ready handshake, immediate legality checking, and saturating statistics counters.

---
 rtl/instr_encoder.sv | 110 +++++++++++
 tb/tb_instr_encoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction word builder: packs fields and a signed immediate into R/I/S/B/U/J
// encodings behind a one-deep valid/ready register, with legality flags and usage counters.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [2:0]       out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               accept;
  logic signed [31:0] imm_s;
  logic [2:0]         err_d;
  logic [31:0]        instr_d;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign imm_s    = signed'(in_imm);

  // err_d bit 0: range, bit 1: low-bit alignment, bit 2: illegal format
  always_comb begin
    err_d   = 3'b000;
    instr_d = 32'h0;
    case (in_fmt)
      FMT_R: begin
        instr_d = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_I: begin
        err_d[0] = (imm_s < -2048) || (imm_s > 2047);
        instr_d  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_S: begin
        err_d[0] = (imm_s < -2048) || (imm_s > 2047);
        instr_d  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      FMT_B: begin
        err_d[0] = (imm_s < -4096) || (imm_s > 4094);
        err_d[1] = in_imm[0];
        instr_d  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
      end
      FMT_U: begin
        err_d[1] = (in_imm[11:0] != 12'h000);
        instr_d  = {in_imm[31:12], in_rd, in_opcode};
      end
      FMT_J: begin
        err_d[0] = (imm_s < -1048576) || (imm_s > 1048574);
        err_d[1] = in_imm[0];
        instr_d  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      default: begin
        err_d[2] = 1'b1;
      end
    endcase
    if (err_d != 3'b000) begin
      instr_d = 32'h0;
    end
  end

  // A push always wins over a pop, so a simultaneous pop/push just replaces the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_err   <= 3'b000;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_instr <= instr_d;
        out_err   <= err_d;
        if (err_d == 3'b000) begin
          if (enc_count != CNT_MAX) enc_count <= enc_count + 1'b1;
        end else begin
          if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued on acceptance and
// compared as the DUT presents them; B/J offsets are also checked by decoding.
module tb_instr_encoder;

  localparam int CNT_W = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;
  localparam int K_EXACT = 0;
  localparam int K_RT_B  = 1;
  localparam int K_RT_J  = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [2:0]       out_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  typedef struct {
    int          kind;
    logic [31:0] instr;
    logic [2:0]  err;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_enc = 0;
  int   exp_err = 0;

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] decB(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] decJ(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the request was taken.
  task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm, input int kind,
                               input logic [31:0] e_instr, input logic [2:0] e_err);
    exp_t e;
    int   n;
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready) begin
      e.kind = kind; e.instr = e_instr; e.err = e_err; e.imm = imm;
      sb.push_back(e);
      if (e_err == 3'b000) begin
        if (exp_enc < CNT_SAT) exp_enc++;
      end else begin
        if (exp_err < CNT_SAT) exp_err++;
      end
    end else begin
      checkOutput("accept_timeout", {31'h0, in_ready}, 32'h1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkCounters(input string tag);
    @(negedge clk);
    checkOutput({tag, "_enc"}, {{(32-CNT_W){1'b0}}, enc_count}, exp_enc);
    checkOutput({tag, "_err"}, {{(32-CNT_W){1'b0}}, err_count}, exp_err);
    @(posedge clk);
    #1;
  endtask

  // Held words must stay stable; consumed words are popped and compared.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_word", sb.size(), 1);
      end else begin
        e = sb[0];
        checkOutput("err", {29'h0, out_err}, {29'h0, e.err});
        if (e.kind == K_RT_B) checkOutput("b_roundtrip", decB(out_instr), e.imm);
        else if (e.kind == K_RT_J) checkOutput("j_roundtrip", decJ(out_instr), e.imm);
        else checkOutput("instr", out_instr, e.instr);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int v;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = 3'd0; in_opcode = 7'h0; in_rd = 5'h0; in_rs1 = 5'h0; in_rs2 = 5'h0;
    in_funct3 = 3'h0; in_funct7 = 7'h0; in_imm = 32'h0;
    #12;
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_out_instr", out_instr, 32'h0);
    checkOutput("rst_out_err", {29'h0, out_err}, 32'h0);
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'hFFFF_FFFF, K_EXACT, 32'hFFF00093, 3'b000);
    waitDrain();
    checkCounters("first");

    // Legal words, including boundary offsets and garbage in unused fields.
    applyStimulus(3'd2, 7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8, K_EXACT, 32'h0020A423, 3'b000);
    applyStimulus(3'd5, 7'h6F, 5'd1, 5'd9, 5'd9, 3'd7, 7'h55, 32'd8, K_EXACT, 32'h008000EF, 3'b000);
    applyStimulus(3'd4, 7'h37, 5'd5, 5'd3, 5'd4, 3'd5, 7'h11, 32'h12345000, K_EXACT, 32'h123452B7, 3'b000);
    applyStimulus(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEADBEEF, K_EXACT, 32'h403100B3, 3'b000);
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2047, K_EXACT, 32'h7FF00093, 3'b000);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h0, 32'd4094, K_RT_B, 32'h0, 3'b000);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'h0, -32'sd4096, K_RT_B, 32'h0, 3'b000);
    applyStimulus(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd1048574, K_RT_J, 32'h0, 3'b000);
    applyStimulus(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, -32'sd1048576, K_RT_J, 32'h0, 3'b000);

    // Illegal requests: word forced to zero, error bits reported.
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2048, K_EXACT, 32'h0, 3'b001);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h0, 32'd3, K_EXACT, 32'h0, 3'b010);
    applyStimulus(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h12345001, K_EXACT, 32'h0, 3'b010);
    applyStimulus(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd0, K_EXACT, 32'h0, 3'b100);
    applyStimulus(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd0, K_EXACT, 32'h0, 3'b100);
    applyStimulus(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h0, -32'sd2049, K_EXACT, 32'h0, 3'b001);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h0, 32'd4096, K_EXACT, 32'h0, 3'b001);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h0, 32'd4095, K_EXACT, 32'h0, 3'b011);
    applyStimulus(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd1048576, K_EXACT, 32'h0, 3'b001);
    applyStimulus(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5, K_EXACT, 32'h0, 3'b010);
    waitDrain();
    checkCounters("mixed");

    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 4095)) * 2 - 4096;
      applyStimulus(3'd3, 7'h63, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                    32'(v), K_RT_B, 32'h0, 3'b000);
      v = int'($urandom_range(0, 1048575)) * 2 - 1048576;
      applyStimulus(3'd5, 7'h6F, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                    32'(v), K_RT_J, 32'h0, 3'b000);
    end
    waitDrain();
    checkCounters("random");

    out_ready = 1'b0;
    fork
      begin
        applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd1, K_EXACT, 32'h00100093, 3'b000);
        applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2, K_EXACT, 32'h00200093, 3'b000);
        applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd3, K_EXACT, 32'h00300093, 3'b000);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        checkOutput("bp_in_ready", {31'h0, in_ready}, 32'h0);
        checkOutput("bp_out_valid", {31'h0, out_valid}, 32'h1);
        out_ready = 1'b1;
      end
    join
    waitDrain();

    out_ready = 1'b0;
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5, K_EXACT, 32'h00500093, 3'b000);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("mid_rst_out_instr", out_instr, 32'h0);
    checkOutput("mid_rst_out_err", {29'h0, out_err}, 32'h0);
    checkOutput("mid_rst_enc", {{(32-CNT_W){1'b0}}, enc_count}, 32'h0);
    checkOutput("mid_rst_err", {{(32-CNT_W){1'b0}}, err_count}, 32'h0);
    sb.delete();
    exp_enc = 0;
    exp_err = 0;
    out_ready = 1'b1;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'(i),
                    K_EXACT, (32'(i) << 20) | 32'h00000093, 3'b000);
    end
    waitDrain();
    checkCounters("sat");
    checkOutput("sat_enc_value", {{(32-CNT_W){1'b0}}, enc_count}, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
